// File: rtl/hamming_encoder_stream.sv
// Registered SEC-DED Hamming(13,8) encoder with a 2-entry output buffer and a delivered-word counter.
// Optional one-shot codeword fault injection is enabled by defining ECC_FAULT_INJ_EN.
module hamming_encoder_stream #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [12:0]        m_code,
  output logic [COUNT_W-1:0] words_sent
`ifdef ECC_FAULT_INJ_EN
  ,
  input  logic               inj_arm,
  input  logic [12:0]        inj_mask
`endif
);

  logic [1:0]         count_q, count_d;
  logic [12:0]        head_q, head_d;
  logic [12:0]        tail_q, tail_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic               push, pop;
  logic [12:0]        fault_mask;
  logic [12:0]        enc_code;

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    c      = '0;
    c[3]   = d[0];
    c[5]   = d[1];
    c[6]   = d[2];
    c[7]   = d[3];
    c[9]   = d[4];
    c[10]  = d[5];
    c[11]  = d[6];
    c[12]  = d[7];
    c[1]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[2]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[4]   = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[8]   = d[4] ^ d[5] ^ d[6] ^ d[7];
    c[0]   = ^c[12:1];
    return c;
  endfunction

  // Handshake outputs depend only on the occupancy register, never on m_ready.
  assign s_ready    = (count_q < 2'd2);
  assign m_valid    = (count_q != 2'd0);
  assign m_code     = head_q;
  assign words_sent = words_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

`ifdef ECC_FAULT_INJ_EN
  logic        arm_q, arm_d;
  logic [12:0] mask_q, mask_d;
  logic        arm_eff;

  // An arm in the same cycle as a push corrupts that push.
  always_comb begin
    arm_eff    = arm_q || inj_arm;
    mask_d     = inj_arm ? inj_mask : mask_q;
    fault_mask = arm_eff ? mask_d : 13'h0000;
    arm_d      = push ? 1'b0 : arm_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q  <= 1'b0;
      mask_q <= 13'h0000;
    end else begin
      arm_q  <= arm_d;
      mask_q <= mask_d;
    end
  end
`else
  assign fault_mask = 13'h0000;
`endif

  assign enc_code = encode(s_data) ^ fault_mask;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    words_d = pop ? words_q + COUNT_W'(1) : words_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = enc_code;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = enc_code;
        end else if (push) begin
          tail_d  = enc_code;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 13'h0000;
      tail_q  <= 13'h0000;
      words_q <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      words_q <= words_d;
    end
  end

endmodule
